// File: rtl/m_mult_seq.sv
// m_mult_seq: sequential unsigned shift-add multiplier.
// Produces one WIDTH x WIDTH product every WIDTH+1 cycles through a
// start/busy/done handshake. Each RUN cycle adds the multiplicand into the
// accumulator when the multiplier LSB is set, then shifts {carry,acc,mplr}
// right by one place.
module m_mult_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_n;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mplr;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] product_q;

  logic               accept;
  logic               step;
  logic               last;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   acc_sh;
  logic [WIDTH-1:0]   mplr_sh;

  // One iteration of the shift-add step: conditional add, then shift the
  // (2*WIDTH+1)-bit {carry,acc,mplr} value right by one.
  always_comb begin
    addend  = mplr[0] ? mcand : '0;
    sum     = {1'b0, acc} + {1'b0, addend};
    acc_sh  = sum[WIDTH:1];
    mplr_sh = {sum[0], mplr[WIDTH-1:1]};
    last    = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_l) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_l) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and datapath enables; abort takes priority over the
  // final iteration so an aborted operation never touches product.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_n = state;
    accept  = 1'b0;
    step    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_n = S_IDLE;
        end else begin
          step = 1'b1;
          if (last) begin
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (start) begin
          accept  = 1'b1;
          state_n = S_RUN;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result register.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      mcand     <= '0;
      acc       <= '0;
      mplr      <= '0;
      cnt       <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand <= a;
      acc   <= '0;
      mplr  <= b;
      cnt   <= '0;
    end else if (step) begin
      acc  <= acc_sh;
      mplr <= mplr_sh;
      cnt  <= cnt + 1'b1;
      if (last) begin
        product_q <= {acc_sh, mplr_sh};
      end
    end
  end

  // Outputs are decodes of registered state, so no input reaches them
  // combinationally.
  assign busy    = (state == S_RUN);
  assign done    = (state == S_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_m_mult_seq.sv
// Self-checking bench for m_mult_seq: directed handshake/boundary tests,
// back-to-back operation, abort, mid-run reset and a randomized regression
// compared against plain a*b arithmetic.
module tb_m_mult_seq;

  localparam int W = 16;

  logic           clk;
  logic           rst_l;
  logic           start;
  logic           abort;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_tests = 0;
  int n_fail  = 0;

  int n_accept = 0;
  int n_abort  = 0;
  int n_done   = 0;

  m_mult_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_l   (rst_l),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] p;
    p = 64'(x) * 64'(y);
    return p[2*W-1:0];
  endfunction

  // Launch one multiply from IDLE; optionally abort during RUN cycle
  // abort_at (0-based). Operands are scrambled while busy. Reports how many
  // observed cycles had busy=1 and the observation index of the done pulse
  // (index i = just after edge E0+i, E0 being the accepting edge).
  task automatic do_mult(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input int abort_at, output int busy_cyc, output int done_at);
    a     = ai;
    b     = bi;
    start = 1'b1;
    abort = 1'b0;
    tick();
    start = 1'b0;
    n_accept++;
    if (abort_at >= 0) n_abort++;
    busy_cyc = 0;
    done_at  = -1;
    for (int i = 0; i < W + 4; i++) begin
      if (busy) busy_cyc++;
      if (done) begin
        done_at = i;
        n_done++;
      end
      a     = W'($urandom);
      b     = W'($urandom);
      abort = (i == abort_at);
      tick();
    end
    abort = 1'b0;
  endtask

  initial begin
    int bc;
    int da;
    int last_done;
    int ops_done;
    int ab;
    logic [W-1:0]   ai;
    logic [W-1:0]   bi;
    logic [2*W-1:0] exp_prod;
    logic [2*W-1:0] expq[$];

    rst_l = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;
    #2;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_l = 1'b1;
    tick();
    check("idle_busy", 64'(busy), 64'd0);

    // Basic multiply with handshake timing.
    do_mult(16'h1234, 16'h5678, -1, bc, da);
    check("t1_busy_cycles", 64'(bc), 64'(W));
    check("t1_done_at", 64'(da), 64'(W));
    check("t1_product", 64'(product), 64'h06260060);

    // Abort on iteration 5 and on the last iteration.
    do_mult(16'hFFFF, 16'hFFFF, 5, bc, da);
    check("abort5_busy_cycles", 64'(bc), 64'd6);
    check("abort5_no_done", 64'(da), 64'hFFFF_FFFF_FFFF_FFFF);
    check("abort5_product", 64'(product), 64'h06260060);
    do_mult(16'hFFFF, 16'hFFFF, W - 1, bc, da);
    check("abortlast_busy_cycles", 64'(bc), 64'(W));
    check("abortlast_no_done", 64'(da), 64'hFFFF_FFFF_FFFF_FFFF);
    check("abortlast_product", 64'(product), 64'h06260060);

    // Boundary operands.
    do_mult(16'hFFFF, 16'hFFFF, -1, bc, da);
    check("max_product", 64'(product), 64'hFFFE0001);
    check("max_done_at", 64'(da), 64'(W));
    do_mult(16'h0000, 16'hBEEF, -1, bc, da);
    check("zero_product", 64'(product), 64'h0);
    do_mult(16'h0001, 16'h8001, -1, bc, da);
    check("one_product", 64'(product), 64'h00008001);

    // Back-to-back: start held high, new operands presented in each DONE cycle.
    ai    = 16'hA5A5;
    bi    = 16'h5A5A;
    a     = ai;
    b     = bi;
    start = 1'b1;
    expq.push_back(ref_mul(ai, bi));
    tick();
    last_done = -1;
    ops_done  = 0;
    for (int cyc = 0; cyc < 8 * (W + 1) + 40 && ops_done < 6; cyc++) begin
      if (done) begin
        check("b2b_product", 64'(product), 64'(expq.pop_front()));
        if (last_done >= 0) check("b2b_interval", 64'(cyc - last_done), 64'(W + 1));
        last_done = cyc;
        ops_done++;
        if (ops_done < 6) begin
          ai = (ops_done % 2 == 1) ? W'($urandom) : ~ai;
          bi = (ops_done % 2 == 1) ? W'($urandom) : ~bi;
          a  = ai;
          b  = bi;
          expq.push_back(ref_mul(ai, bi));
        end else begin
          start = 1'b0;
        end
      end else begin
        if (last_done == cyc - 1 && ops_done < 6 && ops_done > 0)
          check("b2b_accept_in_done", 64'(busy), 64'd1);
        if (busy) begin
          a = W'($urandom);
          b = W'($urandom);
        end
      end
      tick();
    end
    start = 1'b0;
    check("b2b_ops_completed", 64'(ops_done), 64'd6);
    repeat (2) tick();

    // Asynchronous reset in the middle of RUN, between clock edges.
    a     = 16'hABCD;
    b     = 16'h1357;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("midrun_busy_before", 64'(busy), 64'd1);
    #3 rst_l = 1'b0;
    #1;
    check("midrun_rst_busy", 64'(busy), 64'd0);
    check("midrun_rst_done", 64'(done), 64'd0);
    check("midrun_rst_product", 64'(product), 64'd0);
    #2 rst_l = 1'b1;
    tick();
    do_mult(16'd3, 16'd5, -1, bc, da);
    check("after_rst_product", 64'(product), 64'd15);
    check("after_rst_done_at", 64'(da), 64'(W));

    // Randomized regression with occasional aborts.
    n_accept = 0;
    n_abort  = 0;
    n_done   = 0;
    exp_prod = product;
    for (int k = 0; k < 1500; k++) begin
      ai = W'($urandom);
      bi = W'($urandom);
      if ($urandom_range(15) == 0) ai = '1;
      if ($urandom_range(15) == 0) bi = '0;
      ab = ($urandom_range(7) == 0) ? int'($urandom_range(W - 1)) : -1;
      do_mult(ai, bi, ab, bc, da);
      if (ab < 0) begin
        exp_prod = ref_mul(ai, bi);
        check("rand_done_at", 64'(da), 64'(W));
      end else begin
        check("rand_abort_no_done", 64'(da), 64'hFFFF_FFFF_FFFF_FFFF);
      end
      check("rand_product", 64'(product), 64'(exp_prod));
    end
    check("rand_done_count", 64'(n_done), 64'(n_accept - n_abort));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
